// File: rtl/run_detector_onehot_if.sv
// Bus bundle for run_detector_onehot: serial sample/control inputs plus
// the one-hot state and match/status outputs.
interface run_detector_onehot_if #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
);
  logic                 en;
  logic                 w;
  logic [1:0]           mode;
  logic [2*RUN_LEN:0]   state;
  logic                 z;
  logic                 match_pulse;
  logic [CNT_W-1:0]     det_count;
  logic                 err;

  modport master (
    output en, w, mode,
    input  state, z, match_pulse, det_count, err
  );

  modport slave (
    input  en, w, mode,
    output state, z, match_pulse, det_count, err
  );
endinterface

// File: rtl/run_detector_onehot.sv
// One-hot run-length detector on serial input w: flags runs of RUN_LEN or more
// equal bits, with mode qualification, hold, entry pulse, saturating counter and
// illegal-state recovery.
module run_detector_onehot #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  run_detector_onehot_if.slave bus
);
  localparam int N = RUN_LEN;
  localparam int W = 2 * N + 1;
  localparam logic [W-1:0] IDLE_VEC = W'(1);
  localparam logic [N-1:0] FIRST    = N'(1);
  localparam logic [N-1:0] TOP      = N'(1) << (N - 1);
  localparam logic [N-1:0] NONE     = '0;

  typedef enum logic [1:0] {ST_IDLE, ST_ZERO, ST_ONE, ST_BAD} kind_e;

  // state layout (msb..lsb): {O_N..O_1, Z_N..Z_1, IDLE}
  logic [W-1:0]     state_q, state_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] det_q;
  logic             err_q;
  logic             legal;
  kind_e            kind;
  logic [N-1:0]     zv, ov, zsh, osh;

  assign legal = $onehot(state_q);
  assign zv    = state_q[N:1];
  assign ov    = state_q[2*N:N+1];
  // advance one position within a run field; the last position self-loops
  assign zsh   = (zv << 1) | (zv & TOP);
  assign osh   = (ov << 1) | (ov & TOP);

  always_comb begin
    kind = ST_BAD;
    if (legal) begin
      if (state_q[0])  kind = ST_IDLE;
      else if (|zv)    kind = ST_ZERO;
      else             kind = ST_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (kind)
      ST_BAD:  state_d = IDLE_VEC;
      ST_IDLE: if (bus.en) state_d = bus.w ? {FIRST, NONE, 1'b0} : {NONE, FIRST, 1'b0};
      ST_ZERO: if (bus.en) state_d = bus.w ? {FIRST, NONE, 1'b0} : {NONE, zsh, 1'b0};
      ST_ONE:  if (bus.en) state_d = bus.w ? {osh, NONE, 1'b0}   : {NONE, FIRST, 1'b0};
      default: state_d = IDLE_VEC;
    endcase
  end

  // pulse only on entry from a different state, qualified by the mode at that edge
  always_comb begin
    pulse_d = bus.en & legal &
              ((state_d[N]   & ~state_q[N]   & ~bus.mode[1]) |
               (state_d[2*N] & ~state_q[2*N] & ~bus.mode[0]));
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE_VEC;
      pulse_q <= 1'b0;
      det_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      if (pulse_d && det_q != '1) det_q <= det_q + 1'b1;
      if (!legal) err_q <= 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.z           = legal & ((state_q[N] & ~bus.mode[1]) | (state_q[2*N] & ~bus.mode[0]));
  assign bus.match_pulse = pulse_q & legal;
  assign bus.det_count   = det_q;
  assign bus.err         = err_q;
endmodule

// File: doc/run_detector_onehot.md
Name: run_detector_onehot

Overview:
Parametrised one-hot run-length detector, the next generation of the team's fixed five-state w/z one-hot machine. It tracks consecutive equal values on serial input w and flags runs of RUN_LEN or more zeros or ones. It adds a selectable match mode, a hold enable, an entry pulse, a saturating match counter and illegal-state recovery. It sits directly on a sampled serial line as a pattern qualifier for downstream control.

Parameters:
RUN_LEN, 2, run length that constitutes a match; legal range 1..15. RUN_LEN=2 reproduces the legacy A–E machine.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset; overrides all other inputs.
en  input  1  1 = advance the FSM this cycle; 0 = hold all state.
w  input  1  serial data bit.
mode  input  2  00 = match both, 01 = zeros only, 10 = ones only, 11 = match disabled.
state  output  2*RUN_LEN+1  one-hot state vector, registered.
z  output  1  level match flag.
match_pulse  output  1  one-cycle pulse on entry to a qualifying saturated state.
det_count  output  CNT_W  saturating count of match_pulse events.
err  output  1  sticky illegal-state flag.

Behaviour:
- Reset, one clk and synchronous with Reset=1: state = IDLE (bit 0 only), z=0, match_pulse=0, det_count=0, err=0.
- Reset overrides en, w and illegal-state recovery. Reset mid-run discards the run.
- State encoding: bit 0 = IDLE; bits 1..RUN_LEN = Z1..ZN (1..N zeros seen); bits RUN_LEN+1..2*RUN_LEN = O1..ON (1..N ones seen).
- Transitions when en=1:
  - IDLE: w=0 -> Z1; w=1 -> O1.
  - Zk: w=0 -> Z(min(k+1,N)); w=1 -> O1.
  - Ok: w=1 -> O(min(k+1,N)); w=0 -> Z1.
  - ZN and ON are saturating and self-loop on an equal bit.
  - IDLE is never re-entered except via Reset or recovery.
- en=0: state, det_count and err hold. match_pulse=0.
- Matching (Moore, combinational from the registered state):
  - zq = state is ZN and mode is 00 or 01.
  - oq = state is ON and mode is 00 or 10.
  - z = zq | oq.
  - mode=11 forces z=0. A mode change takes effect the same cycle.
- match_pulse is registered and asserts in the first cycle of residence in ZN or ON, i.e. the edge that entered it came from a different state.
  - It is gated by the mode value present at that edge.
  - Staying in ZN/ON does not re-pulse.
  - Direct ZN -> O1 -> ... -> ON re-pulses on the ON entry.
  - RUN_LEN=1: Z1 <-> O1 alternation pulses on every change; a repeated bit does not pulse.
- det_count increments by 1 on each match_pulse and saturates at 2^CNT_W-1 with no wrap.
- Illegal state (zero bits or more than one bit set in state):
  - z=0 and match_pulse=0 while illegal.
  - Next edge forces IDLE regardless of en.
  - err is set and stays set until Reset.
  - det_count is unchanged.
- Latency: w sampled at edge t; state and z reflect it after edge t; match_pulse is high during the cycle following edge t.

Test Plan:
- RUN_LEN=2, mode=00, Reset then w = 0,0,0,1,1 with en=1 -> states Z1,Z2,Z2,O1,O2; z = 0,1,1,0,1; match_pulse high in the Z2-entry and O2-entry cycles only; det_count=2.
- RUN_LEN=3, mode=01, w = 1,1,1,0,0,0 -> z=0 in O3, z=1 in Z3; det_count=1; then switch mode to 11 while in Z3 -> z=0 the same cycle, no pulse.
- en hold: in Z1, drive en=0 for 4 cycles with w toggling -> state stays Z1 and det_count is unchanged; en=1 with w=0 -> Z2 and pulse (RUN_LEN=2).
- Saturation: CNT_W=2, alternate runs 00 11 00 11 00 -> det_count = 1,2,3,3,3.
- Illegal state: force state to 0 and separately to two bits set -> next edge IDLE, err=1; err persists through normal traffic; Reset clears it to 0.
- Reset mid-run: in O1, assert Reset with w=1, en=1 -> IDLE and all outputs zero at the next edge; after release, w=1,1 gives O1, O2 with pulse (RUN_LEN=2).
